// File: rtl/hold85_if.sv
// Bus bundle for hold85_arb: CPU multiplexed bus, HOLD/HLDA pair, DMA requester and memory port.
interface hold85_if #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 16
);
  logic [DATASIZE-1:0]          ad;
  logic [ADDRSIZE-DATASIZE-1:0] a;
  logic                         ale, rd_, wr_, iom_;
  logic                         hold, hlda;
  logic                         dma_req, dma_gnt, dma_abort;
  logic [ADDRSIZE-1:0]          dma_addr;
  logic [DATASIZE-1:0]          dma_wdata;
  logic                         dma_rd, dma_wr;
  logic [ADDRSIZE-1:0]          mem_addr;
  logic [DATASIZE-1:0]          mem_wdata;
  logic                         mem_rd, mem_wr;

  // Arbiter side
  modport slave (
    input  ad, a, ale, rd_, wr_, iom_, hlda,
           dma_req, dma_addr, dma_wdata, dma_rd, dma_wr,
    output hold, dma_gnt, dma_abort, mem_addr, mem_wdata, mem_rd, mem_wr
  );

  // CPU / requester / memory side
  modport master (
    output ad, a, ale, rd_, wr_, iom_, hlda,
           dma_req, dma_addr, dma_wdata, dma_rd, dma_wr,
    input  hold, dma_gnt, dma_abort, mem_addr, mem_wdata, mem_rd, mem_wr
  );
endinterface

// File: rtl/hold85_arb.sv
// HOLD/HLDA arbiter sharing core85 memory between the CPU and one DMA requester,
// with a grant time limit and a guaranteed CPU gap after every release.
module hold85_arb #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 16,
  parameter int MAXHOLD  = 64,
  parameter int GAPCYC   = 4
) (
  input  logic     clk,
  input  logic     rst,
  hold85_if.slave  bus
);
  localparam int CMAX = (MAXHOLD > GAPCYC) ? MAXHOLD : GAPCYC;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAXHOLD - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'((GAPCYC > 0) ? GAPCYC - 1 : 0);

  typedef enum logic [2:0] {IDLE, REQ, DMA, REL, GAP} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic                armed, armed_nxt;
  logic                hold_q, hold_nxt;
  logic                gnt_q, gnt_nxt;
  logic                abort_q, abort_nxt;
  logic [ADDRSIZE-1:0] cpu_addr;
  logic [CW-1:0]       cnt_inc;

  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    armed_nxt = armed | ~bus.dma_req;
    hold_nxt  = 1'b0;
    gnt_nxt   = 1'b0;
    abort_nxt = 1'b0;
    case (state)
      IDLE: if (bus.dma_req && armed) begin
        state_nxt = REQ;
        hold_nxt  = 1'b1;
      end
      // A withdrawn request wins over a late acknowledge: never grant an idle requester.
      REQ: if (!bus.dma_req) begin
        state_nxt = REL;
      end else if (bus.hlda) begin
        state_nxt = DMA;
        hold_nxt  = 1'b1;
        gnt_nxt   = 1'b1;
        cnt_nxt   = '0;
      end else begin
        hold_nxt  = 1'b1;
      end
      DMA: if (!bus.dma_req) begin
        state_nxt = REL;
      end else if (cnt == HOLD_LAST) begin
        state_nxt = REL;
        abort_nxt = 1'b1;
        armed_nxt = 1'b0;
      end else begin
        hold_nxt  = 1'b1;
        gnt_nxt   = 1'b1;
        cnt_nxt   = cnt_inc;
      end
      REL: if (!bus.hlda) begin
        if (GAPCYC > 0) begin
          state_nxt = GAP;
          cnt_nxt   = '0;
        end else begin
          state_nxt = IDLE;
        end
      end
      GAP: begin
        cnt_nxt = cnt_inc;
        if (cnt == GAP_LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      armed    <= 1'b1;
      hold_q   <= 1'b0;
      gnt_q    <= 1'b0;
      abort_q  <= 1'b0;
      cpu_addr <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      armed   <= armed_nxt;
      hold_q  <= hold_nxt;
      gnt_q   <= gnt_nxt;
      abort_q <= abort_nxt;
      if (bus.ale) cpu_addr <= {bus.a, bus.ad};
    end
  end

  assign bus.hold      = hold_q;
  assign bus.dma_gnt   = gnt_q;
  assign bus.dma_abort = abort_q;

  // Memory port follows the registered grant so it flips on the same edge as dma_gnt.
  assign bus.mem_addr  = gnt_q ? bus.dma_addr  : cpu_addr;
  assign bus.mem_wdata = gnt_q ? bus.dma_wdata : bus.ad;
  assign bus.mem_rd    = gnt_q ? bus.dma_rd    : (~bus.rd_ & ~bus.iom_);
  assign bus.mem_wr    = gnt_q ? bus.dma_wr    : (~bus.wr_ & ~bus.iom_);
endmodule

// File: tb/tb_hold85_arb.sv
// Randomized + directed bench for hold85_arb against an ownership/timer model of the bus rules.
module tb_hold85_arb;
  localparam int DW = 8, AW = 16, MAXHOLD = 8, GAPCYC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hold85_if #(.DATASIZE(DW), .ADDRSIZE(AW)) bus ();

  hold85_arb #(.DATASIZE(DW), .ADDRSIZE(AW), .MAXHOLD(MAXHOLD), .GAPCYC(GAPCYC)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int total = 0, bad = 0;
  bit chk_on = 1'b0;
  logic [3:0] hist = '0;
  int lag = 2;

  // Model: who owns the bus, how long it has been granted, and how much gap remains.
  bit          m_hold, m_gnt, m_abort, m_armed, m_relwait;
  int          m_glen, m_gap;
  logic [AW-1:0] m_cpu;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic model_update();
    bit req = bus.dma_req;
    bit abort_now = 1'b0;
    if (rst) begin
      m_hold = 0; m_gnt = 0; m_abort = 0; m_armed = 1; m_relwait = 0;
      m_glen = 0; m_gap = 0; m_cpu = '0;
      return;
    end
    if (bus.ale) m_cpu = {bus.a, bus.ad};
    m_abort = 0;
    if (m_gnt) begin
      if (!req) begin
        m_gnt = 0; m_hold = 0; m_relwait = 1;
      end else if (m_glen == MAXHOLD) begin
        m_gnt = 0; m_hold = 0; m_relwait = 1; m_abort = 1; abort_now = 1;
      end else m_glen++;
    end else if (m_hold) begin
      if (!req) begin
        m_hold = 0; m_relwait = 1;
      end else if (bus.hlda) begin
        m_gnt = 1; m_glen = 1;
      end
    end else if (m_relwait) begin
      if (!bus.hlda) begin
        m_relwait = 0; m_gap = GAPCYC;
      end
    end else if (m_gap > 0) m_gap--;
    else if (req && m_armed) m_hold = 1;
    m_armed = abort_now ? 1'b0 : (m_armed | !req);
  endtask

  // One clock: DUT and model sample the same inputs; the CPU answers hold after `lag` cycles.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    hist = {hist[2:0], bus.hold};
    bus.hlda = hist[lag-1];
  endtask

  task automatic wait_gnt(input int lim);
    int k = 0;
    while (!bus.dma_gnt && k < lim) begin
      step();
      k++;
    end
    if (!bus.dma_gnt) chk("gnt_timeout", 32'(bus.dma_gnt), 32'd1);
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("hold", 32'(bus.hold), 32'(m_hold));
      chk("dma_gnt", 32'(bus.dma_gnt), 32'(m_gnt));
      chk("dma_abort", 32'(bus.dma_abort), 32'(m_abort));
      chk("mem_addr", 32'(bus.mem_addr), 32'(m_gnt ? bus.dma_addr : m_cpu));
      chk("mem_wdata", 32'(bus.mem_wdata), 32'(m_gnt ? bus.dma_wdata : bus.ad));
      chk("mem_rd", 32'(bus.mem_rd), 32'(m_gnt ? bus.dma_rd : (!bus.rd_ && !bus.iom_)));
      chk("mem_wr", 32'(bus.mem_wr), 32'(m_gnt ? bus.dma_wr : (!bus.wr_ && !bus.iom_)));
    end
  end

  initial begin
    int n;
    bus.ad = '0; bus.a = '0; bus.ale = 0; bus.rd_ = 1; bus.wr_ = 1; bus.iom_ = 1;
    bus.hlda = 0; bus.dma_req = 0; bus.dma_addr = '0; bus.dma_wdata = '0;
    bus.dma_rd = 0; bus.dma_wr = 0;

    step();
    chk_on = 1'b1;
    step();
    chk("rst_hold", 32'(bus.hold), 32'd0);
    chk("rst_gnt", 32'(bus.dma_gnt), 32'd0);
    chk("rst_abort", 32'(bus.dma_abort), 32'd0);
    chk("rst_addr", 32'(bus.mem_addr), 32'd0);
    rst = 1'b0;

    // CPU path through the address latch
    bus.ale = 1; bus.a = 8'h20; bus.ad = 8'h01; step();
    bus.ale = 0; bus.ad = 8'h77; bus.rd_ = 0; bus.iom_ = 0; #1;
    chk("cpu_addr", 32'(bus.mem_addr), 32'h2001);
    chk("cpu_rd", 32'(bus.mem_rd), 32'd1);
    chk("cpu_wdata", 32'(bus.mem_wdata), 32'h77);
    bus.iom_ = 1; #1;
    chk("cpu_io_rd", 32'(bus.mem_rd), 32'd0);
    bus.rd_ = 1; step();

    // Basic grant
    bus.dma_addr = 16'h2000; bus.dma_wdata = 8'h5A; bus.dma_req = 1; step();
    chk("req_hold", 32'(bus.hold), 32'd1);
    chk("req_gnt", 32'(bus.dma_gnt), 32'd0);
    step();
    chk("req_wait_gnt", 32'(bus.dma_gnt), 32'd0);
    step();
    chk("gnt_after_hlda", 32'(bus.dma_gnt), 32'd1);
    bus.dma_wr = 1; #1;
    chk("dma_addr", 32'(bus.mem_addr), 32'h2000);
    chk("dma_wdata", 32'(bus.mem_wdata), 32'h5A);
    chk("dma_wr", 32'(bus.mem_wr), 32'd1);
    step(); bus.dma_wr = 0; step();
    bus.dma_req = 0; step();
    chk("rel_gnt", 32'(bus.dma_gnt), 32'd0);
    chk("rel_hold", 32'(bus.hold), 32'd0);
    chk("rel_abort", 32'(bus.dma_abort), 32'd0);

    // Immediate re-request: hold must wait out the gap
    bus.dma_req = 1;
    for (int i = 1; i <= 7; i++) begin
      step();
      chk("gap_hold", 32'(bus.hold), 32'(i == 7));
    end

    // Timeout: requester never lets go
    wait_gnt(10);
    n = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.dma_gnt) n++;
      else break;
    end
    chk("gnt_len", 32'(n), 32'(MAXHOLD));
    chk("abort_pulse", 32'(bus.dma_abort), 32'd1);
    chk("abort_hold", 32'(bus.hold), 32'd0);
    step();
    chk("abort_once", 32'(bus.dma_abort), 32'd0);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("no_regrant", 32'(bus.hold), 32'd0);
    end
    bus.dma_req = 0; step();
    bus.dma_req = 1; step();
    chk("rearm_hold", 32'(bus.hold), 32'd1);

    // Drop exactly when the limit is reached: normal release
    wait_gnt(10);
    repeat (MAXHOLD - 1) step();
    bus.dma_req = 0; step();
    chk("lim_drop_abort", 32'(bus.dma_abort), 32'd0);
    chk("lim_drop_gnt", 32'(bus.dma_gnt), 32'd0);

    // Request withdrawn before hlda
    repeat (12) step();
    bus.dma_req = 1; step();
    chk("wd_hold", 32'(bus.hold), 32'd1);
    bus.dma_req = 0; step();
    chk("wd_hold_drop", 32'(bus.hold), 32'd0);
    chk("wd_gnt", 32'(bus.dma_gnt), 32'd0);
    bus.dma_req = 1;
    for (int i = 2; i <= 8; i++) begin
      step();
      chk("wd_gap", 32'(bus.hold), 32'(i == 8));
    end

    // Reset while granted
    wait_gnt(10);
    rst = 1; step();
    chk("mrst_hold", 32'(bus.hold), 32'd0);
    chk("mrst_gnt", 32'(bus.dma_gnt), 32'd0);
    chk("mrst_addr", 32'(bus.mem_addr), 32'd0);
    rst = 0; bus.dma_req = 0;
    repeat (10) step();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(11) == 0) bus.dma_req = ~bus.dma_req;
      bus.ale       = ($urandom_range(3) == 0);
      bus.a         = 8'($urandom);
      bus.ad        = 8'($urandom);
      bus.rd_       = 1'($urandom);
      bus.wr_       = 1'($urandom);
      bus.iom_      = 1'($urandom);
      bus.dma_addr  = 16'($urandom);
      bus.dma_wdata = 8'($urandom);
      bus.dma_rd    = 1'($urandom);
      bus.dma_wr    = 1'($urandom);
      rst           = ($urandom_range(199) == 0);
      if ($urandom_range(63) == 0) lag = int'($urandom_range(3, 1));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
